alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit bit-slice ALU.
- Operand width is generic. Mode set widens from 4 to 8 operations.
- Adds status flags, optional signed saturation and valid/ready handshakes on both sides.
- Sits between an operand-fetch source and a result consumer. Either side may stall.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SAT, 0, 1 = signed saturation on modes 000/001/100; 0 = wrap-around.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  1  operand set valid.
- in_rdy  output  1  block can accept an operand set this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- mode  input  3  operation select, encoded as below.
- out_vld  output  1  result valid.
- out_rdy  input  1  consumer accepts the result this cycle.
- Y  output  WIDTH  result.
- flags  output  4  {N,Z,C,V} for Y.

Behaviour:
- Reset:
  - One clock; rst_n is asynchronous and active-low. Assertion clears both stage valid bits immediately.
  - Y, flags and the internal operand registers reset to 0. out_vld resets to 0.
  - in_rdy is 1 while idle after reset.
  - Any in-flight transactions are discarded, not completed.
- Mode encoding (two's complement; a = A, b = B):
  - 000: (a >>> 1) + b. Arithmetic shift; the sign bit is kept.
  - 001: a - b.
  - 010: a >> 1, logical.
  - 011: a << 1.
  - 100: a + b.
  - 101: a & b.
  - 110: a | b.
  - 111: a ^ b.
- Pipeline: two register stages, S1 (operands + mode) and S2 (result + flags).
- Transfers:
  - Input transfer happens when in_vld && in_rdy.
  - Output transfer happens when out_vld && out_rdy.
- Latency: a set accepted at edge k is presented on Y/out_vld after edge k+1. Throughput is one result per cycle when out_rdy = 1.
- Ready chain, combinational, no skid buffer:
  - rdy2 = !s2_vld | out_rdy.
  - in_rdy = !s1_vld | rdy2.
- S2 loads from S1 when s1_vld && rdy2. S1 loads from the inputs on an input transfer.
- A stage that neither loads nor drains holds its contents unchanged. Y is stable while out_vld && !out_rdy.
- The result is computed combinationally from S1 and registered into S2 together with the flags.
- out_vld is s2_vld. Ordering is strictly FIFO. A stage may load and drain in the same cycle.
- Flags:
  - N = Y[WIDTH-1].
  - Z = (Y == 0).
  - C depends on mode:
    - Modes 000/100: carry-out of the WIDTH-bit add.
    - Mode 001: carry-out of a + ~b + 1, so 1 means a >= b unsigned, i.e. no borrow.
    - Mode 010: a[0].
    - Mode 011: a[WIDTH-1].
    - Logic modes: 0.
  - V depends on mode:
    - Modes 000/001/100: signed overflow of the pre-saturation sum/difference.
    - Mode 011: a[WIDTH-1] ^ a[WIDTH-2].
    - Other modes: 0.
  - Flags are computed from the wrapped result. C and V are never altered by saturation. N and Z follow the final Y.
- SAT = 1:
  - Modes 000/001/100 with V = 1 clamp Y to the signed maximum (0111…1) if the true result is positive, or to the signed minimum (1000…0) if it is negative.
  - Mode 011 is never saturated.
- Boundaries:
  - mode, A and B are sampled only on an input transfer. Changes while in_rdy = 0 are ignored.
  - in_vld deasserting without a transfer has no effect.
  - out_rdy may be high with out_vld low; no effect.
  - Reset asserted in any stall state returns to idle on the next edge after deassertion.

Test Plan:
- WIDTH=8, SAT=0: mode 100, A=0x7F, B=0x01 -> Y=0x80, N=1 Z=0 C=0 V=1, two edges after acceptance.
- Same with SAT=1 -> Y=0x7F, N=0 Z=0 C=0 V=1. Then mode 001, A=0x80, B=0x01 -> Y=0x80, V=1.
- Mode 001, A=0x05, B=0x05 -> Y=0x00, Z=1 C=1. Then A=0x03, B=0x05 -> Y=0xFE, N=1 C=0 V=0.
- Mode 000, A=0x80, B=0x10 -> Y=0xD0, N=1 C=0 V=0. Mode 011, A=0x81 -> Y=0x02, C=1 V=1. Mode 010, A=0x81 -> Y=0x40, C=1.
- Backpressure: out_rdy=0 and three back-to-back sets (100 / 1+1, 2+2, 3+3):
  - First two are accepted; in_rdy drops for the third and Y holds 0x02.
  - Raise out_rdy -> results 0x02, 0x04, 0x06 in order, one per cycle.
- Reset: assert rst_n=0 mid-cycle with both stages full -> out_vld, Y and flags go to 0 immediately without a clock. After release, in_rdy=1 and no stale result appears.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 holds the accepted operands and mode, S2 holds the registered result and
// {N,Z,C,V} flags. The ready chain is combinational, with no skid buffer.
module alu_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       mode,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] Y,
    output logic [3:0]       flags
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned SW  = WIDTH + 1;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] M_ASR_ADD = 3'b000;
    localparam logic [2:0] M_SUB     = 3'b001;
    localparam logic [2:0] M_SHR     = 3'b010;
    localparam logic [2:0] M_SHL     = 3'b011;
    localparam logic [2:0] M_ADD     = 3'b100;
    localparam logic [2:0] M_AND     = 3'b101;
    localparam logic [2:0] M_OR      = 3'b110;
    localparam logic [2:0] M_XOR     = 3'b111;

    // Stage 1: operand set
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_mode;

    // Stage 2: result and flags
    logic             r_s2_vld;
    logic [WIDTH-1:0] r_y;
    logic [3:0]       r_flags;

    // Handshake wires
    logic w_rdy2;
    logic w_in_xfer;
    logic w_s2_load;
    logic w_out_xfer;

    // Datapath wires
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic             w_arith;
    logic [SW-1:0]    w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_wrap;
    logic             w_c;
    logic             w_v;
    logic             w_sat_hit;
    logic [WIDTH-1:0] w_res;
    logic             w_n;
    logic             w_z;

    // Ready chain: a stage can take new data if it is empty or draining.
    assign w_rdy2     = !r_s2_vld || out_rdy;
    assign in_rdy     = !r_s1_vld || w_rdy2;
    assign w_in_xfer  = in_vld && in_rdy;
    assign w_s2_load  = r_s1_vld && w_rdy2;
    assign w_out_xfer = r_s2_vld && out_rdy;

    assign out_vld = r_s2_vld;
    assign Y       = r_y;
    assign flags   = r_flags;

    // Stage 1 register: capture operands on an input transfer, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= '0;
        end else if (w_in_xfer) begin
            r_s1_vld <= 1'b1;
            r_a      <= A;
            r_b      <= B;
            r_mode   <= mode;
        end else if (w_s2_load) begin
            r_s1_vld <= 1'b0;
        end
    end

    // Adder operand select: shifted A for mode 000, inverted B plus carry-in for subtract.
    always_comb begin
        w_x     = r_a;
        w_y     = r_b;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (r_mode)
            M_ASR_ADD: begin
                w_x     = {r_a[MSB], r_a[MSB:1]};
                w_arith = 1'b1;
            end
            M_SUB: begin
                w_y     = ~r_b;
                w_cin   = 1'b1;
                w_arith = 1'b1;
            end
            M_ADD: begin
                w_arith = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Shared (WIDTH+1)-bit adder; the top bit is the carry-out.
    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + SW'(w_cin);

    // Signed overflow: both adder inputs share a sign that the sum does not.
    assign w_ovf = (w_x[MSB] == w_y[MSB]) && (w_sum[MSB] != w_x[MSB]);

    // Wrapped result plus carry and overflow flags per mode.
    always_comb begin
        w_wrap = w_sum[MSB:0];
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (r_mode)
            M_ASR_ADD, M_SUB, M_ADD: begin
                w_c = w_sum[WIDTH];
                w_v = w_ovf;
            end
            M_SHR: begin
                w_wrap = {1'b0, r_a[MSB:1]};
                w_c    = r_a[0];
            end
            M_SHL: begin
                w_wrap = {r_a[MSB-1:0], 1'b0};
                w_c    = r_a[MSB];
                w_v    = r_a[MSB] ^ r_a[MSB-1];
            end
            M_AND: begin
                w_wrap = r_a & r_b;
            end
            M_OR: begin
                w_wrap = r_a | r_b;
            end
            M_XOR: begin
                w_wrap = r_a ^ r_b;
            end
            default: begin
            end
        endcase
    end

    // Saturation: on overflow the true sign equals the shared input sign.
    assign w_sat_hit = (SAT != 0) && w_arith && w_ovf;
    assign w_res     = w_sat_hit ? (w_x[MSB] ? SMIN : SMAX) : w_wrap;
    assign w_n       = w_res[MSB];
    assign w_z       = (w_res == '0);

    // Stage 2 register: load the result from S1, clear on drain, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_y      <= '0;
            r_flags  <= '0;
        end else if (w_s2_load) begin
            r_s2_vld <= 1'b1;
            r_y      <= w_res;
            r_flags  <= {w_n, w_z, w_c, w_v};
        end else if (w_out_xfer) begin
            r_s2_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed table-driven checks of alu_pipe with WIDTH=8, running
// a wrap-around instance and a saturating instance side by side, plus
// hand-written backpressure and asynchronous-reset sequences.
module tb_alu_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_vld;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] mode;
    logic       out_rdy;

    logic       in_rdy0, out_vld0, in_rdy1, out_vld1;
    logic [7:0] y0, y1;
    logic [3:0] f0, f1;

    int checks;
    int errors;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y0;
        logic [3:0] f0;
        logic [7:0] y1;
        logic [3:0] f1;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    alu_pipe #(.WIDTH(8), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy0),
        .A(a), .B(b), .mode(mode), .out_vld(out_vld0), .out_rdy(out_rdy),
        .Y(y0), .flags(f0)
    );

    alu_pipe #(.WIDTH(8), .SAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy1),
        .A(a), .B(b), .mode(mode), .out_vld(out_vld1), .out_rdy(out_rdy),
        .Y(y1), .flags(f1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        a       = '0;
        b       = '0;
        mode    = '0;
        out_rdy = 1'b1;

        //                mode    A      B      Y wrap  NZCV     Y sat   NZCV
        vecs[0]  = '{3'b100, 8'h7F, 8'h01, 8'h80, 4'b1001, 8'h7F, 4'b0001};
        vecs[1]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0011, 8'h80, 4'b1011};
        vecs[2]  = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b0110, 8'h00, 4'b0110};
        vecs[3]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 4'b1000, 8'hFE, 4'b1000};
        vecs[4]  = '{3'b000, 8'h80, 8'h10, 8'hD0, 4'b1000, 8'hD0, 4'b1000};
        vecs[5]  = '{3'b011, 8'h81, 8'h00, 8'h02, 4'b0011, 8'h02, 4'b0011};
        vecs[6]  = '{3'b010, 8'h81, 8'h00, 8'h40, 4'b0010, 8'h40, 4'b0010};
        vecs[7]  = '{3'b101, 8'hF0, 8'h3C, 8'h30, 4'b0000, 8'h30, 4'b0000};
        vecs[8]  = '{3'b110, 8'hF0, 8'h0F, 8'hFF, 4'b1000, 8'hFF, 4'b1000};
        vecs[9]  = '{3'b111, 8'hAA, 8'hAA, 8'h00, 4'b0100, 8'h00, 4'b0100};
        vecs[10] = '{3'b000, 8'h7F, 8'h7F, 8'hBE, 4'b1001, 8'h7F, 4'b0001};
        vecs[11] = '{3'b100, 8'h80, 8'h80, 8'h00, 4'b0111, 8'h80, 4'b1011};
        vecs[12] = '{3'b100, 8'hFF, 8'h01, 8'h00, 4'b0110, 8'h00, 4'b0110};
        vecs[13] = '{3'b011, 8'h40, 8'h00, 8'h80, 4'b1001, 8'h80, 4'b1001};

        // Reset state, sampled while reset is held
        #3;
        chk("rst_out_vld", 32'(out_vld0), 32'd0);
        chk("rst_y", 32'(y0), 32'd0);
        chk("rst_flags", 32'(f0), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy0), 32'd1);
        #9;
        rst_n = 1'b1;
        step();

        // Table: accept at edge k, result visible after edge k+1
        for (int i = 0; i < NV; i++) begin
            mode   = vecs[i].mode;
            a      = vecs[i].a;
            b      = vecs[i].b;
            in_vld = 1'b1;
            chk($sformatf("v%0d_in_rdy", i), 32'(in_rdy0), 32'd1);
            step();
            in_vld = 1'b0;
            chk($sformatf("v%0d_latency", i), 32'(out_vld0), 32'd0);
            step();
            chk($sformatf("v%0d_out_vld", i), 32'(out_vld0), 32'd1);
            chk($sformatf("v%0d_y_wrap", i), 32'(y0), 32'(vecs[i].y0));
            chk($sformatf("v%0d_f_wrap", i), 32'(f0), 32'(vecs[i].f0));
            chk($sformatf("v%0d_y_sat", i), 32'(y1), 32'(vecs[i].y1));
            chk($sformatf("v%0d_f_sat", i), 32'(f1), 32'(vecs[i].f1));
        end
        step();
        chk("drain_out_vld", 32'(out_vld0), 32'd0);

        // Backpressure: three back-to-back sets with the consumer stalled
        out_rdy = 1'b0;
        mode    = 3'b100;
        a       = 8'h01;
        b       = 8'h01;
        in_vld  = 1'b1;
        step();
        a = 8'h02;
        b = 8'h02;
        chk("bp_in_rdy_second", 32'(in_rdy0), 32'd1);
        step();
        a = 8'h03;
        b = 8'h03;
        chk("bp_out_vld", 32'(out_vld0), 32'd1);
        chk("bp_y_first", 32'(y0), 32'h02);
        chk("bp_in_rdy_third", 32'(in_rdy0), 32'd0);
        for (int s = 0; s < 2; s++) begin
            step();
            chk($sformatf("bp_hold_in_rdy%0d", s), 32'(in_rdy0), 32'd0);
            chk($sformatf("bp_hold_y%0d", s), 32'(y0), 32'h02);
            chk($sformatf("bp_hold_vld%0d", s), 32'(out_vld0), 32'd1);
        end
        out_rdy = 1'b1;
        #1;
        chk("bp_in_rdy_release", 32'(in_rdy0), 32'd1);
        chk("bp_y_out0", 32'(y0), 32'h02);
        step();
        in_vld = 1'b0;
        chk("bp_vld_out1", 32'(out_vld0), 32'd1);
        chk("bp_y_out1", 32'(y0), 32'h04);
        step();
        chk("bp_vld_out2", 32'(out_vld0), 32'd1);
        chk("bp_y_out2", 32'(y0), 32'h06);
        step();
        chk("bp_empty", 32'(out_vld0), 32'd0);

        // Asynchronous reset with both stages full
        out_rdy = 1'b0;
        mode    = 3'b100;
        a       = 8'h10;
        b       = 8'h10;
        in_vld  = 1'b1;
        step();
        a = 8'h20;
        b = 8'h20;
        step();
        in_vld = 1'b0;
        chk("rf_out_vld", 32'(out_vld0), 32'd1);
        chk("rf_y", 32'(y0), 32'h20);
        chk("rf_in_rdy", 32'(in_rdy0), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_out_vld", 32'(out_vld0), 32'd0);
        chk("ra_y", 32'(y0), 32'd0);
        chk("ra_flags", 32'(f0), 32'd0);
        chk("ra_in_rdy", 32'(in_rdy0), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("ra_no_stale%0d", s), 32'(out_vld0), 32'd0);
            chk($sformatf("ra_in_rdy%0d", s), 32'(in_rdy0), 32'd1);
        end

        // Post-reset transaction flows normally
        mode   = 3'b100;
        a      = 8'h01;
        b      = 8'h02;
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        step();
        chk("pr_out_vld", 32'(out_vld0), 32'd1);
        chk("pr_y", 32'(y0), 32'h03);
        chk("pr_flags", 32'(f0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
